// File: rtl/uart_rx_axis_fifo.sv
// uart_rx_axis_fifo: oversampling-free UART receiver feeding an AXI-Stream FIFO.
// Optional parity checking is compiled in with macro UART_RX_PARITY_EN.
`default_nettype none

module uart_rx_axis_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          rx_i,
  input  logic [16:0]                   baud_div_i,
  output logic [DATA_WIDTH-1:0]         mst_axis_tdata_o,
  output logic                          mst_axis_tvalid_o,
  input  logic                          mst_axis_tready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          frame_err_o,
  output logic                          parity_err_o,
  output logic                          overrun_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic                  sync1, sync2, rx_prev;
  state_t                state;
  logic [16:0]           div, cnt;
  logic [3:0]            bit_cnt;
  logic [DATA_WIDTH-1:0] shift, push_data;
  logic                  frame_bad, par_bad, push_req;
  logic                  start_edge, bit_tick, half_tick, stop_fail;

  assign start_edge = rx_prev & ~sync2;
  assign bit_tick   = (cnt == div - 17'd1);
  assign half_tick  = (cnt == (div >> 1) - 17'd1);
  assign stop_fail  = frame_bad | ~sync2;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx_i;
      sync2   <= sync1;
      rx_prev <= sync2;
    end
  end

`ifdef UART_RX_PARITY_EN
  localparam logic ODD_BIT = (PARITY_ODD != 0);
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = (PARITY_ODD != 0);
  assign par_bad      = 1'b0;
  assign parity_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      div         <= 17'd4;
      cnt         <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      push_data   <= '0;
      frame_bad   <= 1'b0;
      push_req    <= 1'b0;
      frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad      <= 1'b0;
      parity_err_o <= 1'b0;
`endif
    end else begin
      push_req    <= 1'b0;
      frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start_edge) begin
            state <= START;
            div   <= (baud_div_i < 17'd4) ? 17'd4 : baud_div_i;
            cnt   <= '0;
          end
        end
        START: begin
          if (half_tick) begin
            cnt       <= '0;
            bit_cnt   <= '0;
            frame_bad <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad   <= 1'b0;
`endif
            // A line already back high at mid-start is a glitch, not a frame
            state     <= sync2 ? IDLE : DATA;
          end else begin
            cnt <= cnt + 17'd1;
          end
        end
        DATA: begin
          if (bit_tick) begin
            cnt   <= '0;
            shift <= {sync2, shift[DATA_WIDTH-1:1]};
            if (bit_cnt == 4'(DATA_WIDTH - 1)) begin
              bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            cnt <= cnt + 17'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bit_tick) begin
            cnt     <= '0;
            par_bad <= sync2 ^ (^shift) ^ ODD_BIT;
            state   <= STOP;
          end else begin
            cnt <= cnt + 17'd1;
          end
        end
`endif
        STOP: begin
          if (bit_tick) begin
            cnt       <= '0;
            frame_bad <= stop_fail;
            if (bit_cnt == 4'(STOP_BITS - 1)) begin
              state       <= IDLE;
              push_req    <= ~stop_fail & ~par_bad;
              push_data   <= shift;
              frame_err_o <= stop_fail;
`ifdef UART_RX_PARITY_EN
              parity_err_o <= par_bad;
`endif
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            cnt <= cnt + 17'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wptr, rptr;
  logic                  full, pop, push;

  assign full              = (fifo_level_o == (AW+1)'(FIFO_DEPTH));
  assign pop               = mst_axis_tvalid_o & mst_axis_tready_i;
  // When full, a simultaneous pop frees the head slot that the write reuses
  assign push              = push_req & (~full | pop);
  assign mst_axis_tvalid_o = (fifo_level_o != '0);
  assign mst_axis_tdata_o  = mem[rptr];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr         <= '0;
      rptr         <= '0;
      fifo_level_o <= '0;
      overrun_o    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      overrun_o <= push_req & full & ~pop;
      if (push) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      if (push && !pop)      fifo_level_o <= fifo_level_o + (AW+1)'(1);
      else if (!push && pop) fifo_level_o <= fifo_level_o - (AW+1)'(1);
    end
  end

endmodule

`default_nettype wire
